// File: rtl/pixel_pkg.sv
// Shared display constants, blank colour and the fetch FSM encoding
// used by the pixel fetch path.
package pixel_pkg;

  localparam int DISPLAY_WIDTH  = 800;
  localparam int DISPLAY_HEIGHT = 480;
  localparam int ADDR_VALID_BIT = 19;

  localparam logic [15:0] BLANK_COLOUR = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_POP   = 2'd1,
    ST_ISSUE = 2'd2
  } fetch_state_e;

  // Bit 19 of a pixel-map entry marks an on-screen (fetchable) address.
  function automatic logic addr_is_valid(input logic [ADDR_VALID_BIT:0] entry);
    return entry[ADDR_VALID_BIT];
  endfunction

endpackage

// File: rtl/pixel_sync_fifo.sv
// Single-clock FIFO with count and same-cycle push/pop; when empty, a
// simultaneous push and pop passes the pushed word straight through.
module pixel_sync_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = empty ? wr_data : mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && (!full || pop);
    do_pop   = pop && (!empty || push);
    // Power-of-two depth: pointers wrap by plain overflow.
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/pixel_fetch_ctrl.sv
// Pops pixel-map addresses, issues in-order frame-buffer reads and
// buffers returned (or blank) pixels for the LCD driver.
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   ST_IDLE  | waiting for an address and output credit; pops FIFO
//   ST_POP   | FIFO word valid; push tag, start read if on-screen
//   ST_ISSUE | oMEM_RD held with oMEM_ADDR until iMEM_GNT
module pixel_fetch_ctrl
  import pixel_pkg::*;
#(
  parameter int              DATA_W       = 16,
  parameter int              ADDR_W       = 19,
  parameter int              OUT_DEPTH    = 8,
  parameter int              MAX_OUTST    = 4,
  parameter logic [DATA_W-1:0] BLANK_COLOUR = pixel_pkg::BLANK_COLOUR
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                iADDR_EMPTY,
  input  logic [19:0]         iADDRESS,
  output logic                oADDR_READ,
  output logic [ADDR_W-1:0]   oMEM_ADDR,
  output logic                oMEM_RD,
  input  logic                iMEM_GNT,
  input  logic [DATA_W-1:0]   iMEM_RDATA,
  input  logic                iMEM_RVALID,
  input  logic                iPIX_REQ,
  output logic [DATA_W-1:0]   oPIX_DATA,
  output logic                oUNDERFLOW
);

  localparam int CW  = $clog2(OUT_DEPTH) + 1;
  localparam int TCW = $clog2(MAX_OUTST) + 1;

  fetch_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_rd_q, mem_rd_d;
  logic [DATA_W-1:0]   pix_data_q, pix_data_d;
  logic                underflow_q, underflow_d;

  logic                tag_push, tag_wr, tag_pop, tag_head;
  logic                tag_full, tag_empty;
  logic [TCW-1:0]      tag_count;

  logic                out_push, out_pop;
  logic [DATA_W-1:0]   out_wr, out_head;
  logic                out_full, out_empty;
  logic [CW-1:0]       out_count;

  logic [CW-1:0]       space;
  logic                can_pop;
  logic                addr_read;

  // Every slot in the output buffer is reserved when its tag is pushed, so
  // a returning pixel always has room and pops stop once credit runs out.
  assign space   = CW'(OUT_DEPTH) - out_count - CW'(tag_count);
  assign can_pop = !iADDR_EMPTY && (space != '0) && !tag_full && !out_full;

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = mem_rd_q;
    addr_read  = 1'b0;
    tag_push   = 1'b0;
    tag_wr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (can_pop) begin
          addr_read = 1'b1;
          state_d   = ST_POP;
        end
      end
      ST_POP: begin
        tag_push = 1'b1;
        if (addr_is_valid(iADDRESS)) begin
          tag_wr     = 1'b1;
          mem_addr_d = iADDRESS[ADDR_W-1:0];
          mem_rd_d   = 1'b1;
          state_d    = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (iMEM_GNT) begin
          mem_rd_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        mem_rd_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // Retire: blank tags complete at once; read tags wait for their data.
  // Returns with no matching read tag are discarded.
  always_comb begin
    out_push = 1'b0;
    out_wr   = BLANK_COLOUR;
    tag_pop  = 1'b0;
    if (!tag_empty) begin
      if (!tag_head) begin
        out_push = 1'b1;
        tag_pop  = 1'b1;
      end else if (iMEM_RVALID) begin
        out_push = 1'b1;
        out_wr   = iMEM_RDATA;
        tag_pop  = 1'b1;
      end
    end
  end

  always_comb begin
    pix_data_d  = pix_data_q;
    underflow_d = 1'b0;
    out_pop     = 1'b0;
    if (iPIX_REQ) begin
      if (!out_empty || out_push) begin
        out_pop    = 1'b1;
        pix_data_d = out_head;
      end else begin
        pix_data_d  = BLANK_COLOUR;
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      pix_data_q  <= BLANK_COLOUR;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      pix_data_q  <= pix_data_d;
      underflow_q <= underflow_d;
    end
  end

  pixel_sync_fifo #(
    .WIDTH (1),
    .DEPTH (MAX_OUTST)
  ) u_tag_q (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .push    (tag_push),
    .wr_data (tag_wr),
    .pop     (tag_pop),
    .rd_data (tag_head),
    .full    (tag_full),
    .empty   (tag_empty),
    .count   (tag_count)
  );

  pixel_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (OUT_DEPTH)
  ) u_out_buf (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .push    (out_push),
    .wr_data (out_wr),
    .pop     (out_pop),
    .rd_data (out_head),
    .full    (out_full),
    .empty   (out_empty),
    .count   (out_count)
  );

  assign oADDR_READ = addr_read;
  assign oMEM_ADDR  = mem_addr_q;
  assign oMEM_RD    = mem_rd_q;
  assign oPIX_DATA  = pix_data_q;
  assign oUNDERFLOW = underflow_q;

endmodule

// File: tb/tb_pixel_fetch_ctrl.sv
// Directed bench for pixel_fetch_ctrl with an address-FIFO model and an
// in-order frame-buffer memory model with programmable grant/return delay.
module tb_pixel_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        iADDR_EMPTY = 1'b1;
  logic [19:0] iADDRESS = '0;
  logic        oADDR_READ;
  logic [18:0] oMEM_ADDR;
  logic        oMEM_RD;
  logic        iMEM_GNT = 1'b0;
  logic [15:0] iMEM_RDATA = 16'hDEAD;
  logic        iMEM_RVALID = 1'b0;
  logic        iPIX_REQ = 1'b0;
  logic [15:0] oPIX_DATA;
  logic        oUNDERFLOW;

  pixel_fetch_ctrl dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .iADDR_EMPTY (iADDR_EMPTY),
    .iADDRESS    (iADDRESS),
    .oADDR_READ  (oADDR_READ),
    .oMEM_ADDR   (oMEM_ADDR),
    .oMEM_RD     (oMEM_RD),
    .iMEM_GNT    (iMEM_GNT),
    .iMEM_RDATA  (iMEM_RDATA),
    .iMEM_RVALID (iMEM_RVALID),
    .iPIX_REQ    (iPIX_REQ),
    .oPIX_DATA   (oPIX_DATA),
    .oUNDERFLOW  (oUNDERFLOW)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          due;
    logic [15:0] data;
  } ret_t;

  ret_t        ret_q[$];
  logic [19:0] addr_q[$];
  logic [18:0] gnt_addr_q[$];
  int          cyc = 0;
  int          gnt_delay = 0;
  int          rlat = 3;
  int          wait_cnt = 0;
  int          rd_cycles = 0;
  int          addr_changes = 0;
  int          pops_total = 0;
  bit          pend = 1'b0;
  logic        prev_rd = 1'b0;
  logic [18:0] prev_addr = '0;
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic logic [15:0] mem_word(input logic [18:0] a);
    case (a)
      19'd5:   return 16'hABCD;
      19'd10:  return 16'h1111;
      19'd11:  return 16'h2222;
      default: return a[15:0] ^ 16'h5A5A;
    endcase
  endfunction

  always @(posedge CLK) cyc++;

  // Upstream FIFO and memory models: inputs change 1 ns after the falling
  // edge, the pop request is sampled once those inputs have settled.
  always @(negedge CLK) begin
    #1;
    if (pend && addr_q.size() > 0) iADDRESS = addr_q.pop_front();
    pend = 1'b0;
    iADDR_EMPTY = (addr_q.size() == 0);
    iMEM_GNT = 1'b0;
    if (oMEM_RD) begin
      rd_cycles++;
      if (prev_rd && oMEM_ADDR != prev_addr) addr_changes++;
      if (wait_cnt >= gnt_delay) begin
        iMEM_GNT = 1'b1;
        gnt_addr_q.push_back(oMEM_ADDR);
        ret_q.push_back('{cyc + rlat, mem_word(oMEM_ADDR)});
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
    prev_rd   = oMEM_RD;
    prev_addr = oMEM_ADDR;
    iMEM_RVALID = 1'b0;
    iMEM_RDATA  = 16'hDEAD;
    if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
      iMEM_RVALID = 1'b1;
      iMEM_RDATA  = ret_q[0].data;
      void'(ret_q.pop_front());
    end
    #1;
    if (oADDR_READ) begin
      pend = 1'b1;
      pops_total++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset(input bit keep_returns);
    @(negedge CLK);
    RESET_N = 1'b0;
    iPIX_REQ = 1'b0;
    addr_q.delete();
    gnt_addr_q.delete();
    if (!keep_returns) ret_q.delete();
    pend = 1'b0;
    wait_cnt = 0;
    rd_cycles = 0;
    addr_changes = 0;
    pops_total = 0;
    gnt_delay = 0;
    rlat = 3;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  task automatic pix_read(input string tag, input logic [15:0] exp_data, input logic exp_uf);
    iPIX_REQ = 1'b1;
    @(negedge CLK);
    iPIX_REQ = 1'b0;
    check_val(tag, oPIX_DATA, exp_data);
    check_val({tag, "_uf"}, oUNDERFLOW, exp_uf);
  endtask

  task automatic wait_grants(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && gnt_addr_q.size() < n; i++) @(negedge CLK);
    check_val(tag, gnt_addr_q.size(), n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // 1: reset values, single valid fetch with immediate grant
    do_reset(1'b0);
    check_val("rst_addr_read", oADDR_READ, 1'b0);
    check_val("rst_mem_rd", oMEM_RD, 1'b0);
    check_val("rst_mem_addr", oMEM_ADDR, 19'd0);
    check_val("rst_pix", oPIX_DATA, 16'h0000);
    check_val("rst_uf", oUNDERFLOW, 1'b0);
    rlat = 3;
    addr_q.push_back({1'b1, 19'd5});
    idle(15);
    check_val("t1_grants", gnt_addr_q.size(), 1);
    check_val("t1_addr", gnt_addr_q[0], 19'd5);
    check_val("t1_rd_cycles", rd_cycles, 1);
    pix_read("t1_pix", 16'hABCD, 1'b0);
    idle(3);
    check_val("t1_hold", oPIX_DATA, 16'hABCD);

    // 5: request against an empty buffer
    pix_read("t5_pix", 16'h0000, 1'b1);
    @(negedge CLK);
    check_val("t5_uf_pulse", oUNDERFLOW, 1'b0);
    check_val("t5_hold", oPIX_DATA, 16'h0000);

    // 2: valid / invalid / valid keeps order, blank needs no read
    do_reset(1'b0);
    rlat = 5;
    addr_q.push_back({1'b1, 19'd10});
    addr_q.push_back({1'b0, 19'd77});
    addr_q.push_back({1'b1, 19'd11});
    idle(40);
    check_val("t2_grants", gnt_addr_q.size(), 2);
    check_val("t2_addr0", gnt_addr_q[0], 19'd10);
    check_val("t2_addr1", gnt_addr_q[1], 19'd11);
    pix_read("t2_pix0", 16'h1111, 1'b0);
    pix_read("t2_pix1", 16'h0000, 1'b0);
    pix_read("t2_pix2", 16'h2222, 1'b0);

    // 3: no consumer, endless addresses -> credit stops after 8 pops
    do_reset(1'b0);
    rlat = 2;
    for (int i = 0; i < 12; i++) addr_q.push_back({1'b1, 19'(100 + i)});
    idle(60);
    check_val("t3_pops", pops_total, 8);
    check_val("t3_fifo_left", addr_q.size(), 4);
    check_val("t3_addr_read", oADDR_READ, 1'b0);
    for (int i = 0; i < 8; i++) pix_read($sformatf("t3_pix%0d", i), mem_word(19'(100 + i)), 1'b0);

    // 4: grant withheld for 20 cycles
    do_reset(1'b0);
    gnt_delay = 20;
    rlat = 1;
    addr_q.push_back({1'b1, 19'd200});
    idle(40);
    check_val("t4_rd_cycles", rd_cycles, 21);
    check_val("t4_addr_stable", addr_changes, 0);
    check_val("t4_grants", gnt_addr_q.size(), 1);
    check_val("t4_addr", gnt_addr_q[0], 19'd200);
    pix_read("t4_pix", mem_word(19'd200), 1'b0);

    // 6: reset with two reads in flight, late returns must be discarded
    do_reset(1'b0);
    rlat = 10;
    addr_q.push_back({1'b1, 19'd300});
    addr_q.push_back({1'b1, 19'd301});
    wait_grants("t6_pre_grants", 2, 30);
    do_reset(1'b1);
    idle(15);
    check_val("t6_mem_rd", oMEM_RD, 1'b0);
    check_val("t6_pix_rst", oPIX_DATA, 16'h0000);
    check_val("t6_uf_rst", oUNDERFLOW, 1'b0);
    check_val("t6_addr_read", oADDR_READ, 1'b0);
    pix_read("t6_drop", 16'h0000, 1'b1);
    rlat = 2;
    addr_q.push_back({1'b1, 19'd400});
    idle(15);
    check_val("t6_grants", gnt_addr_q.size(), 1);
    check_val("t6_addr", gnt_addr_q[0], 19'd400);
    pix_read("t6_pix", mem_word(19'd400), 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
